// File: rtl/p2p_reg_pkg.sv
// Shared constants, response codes, FSM states and counter-address decode
// for the p2p control/status register block.
package p2p_reg_pkg;

  localparam logic [11:0] REG_ID         = 12'h000;
  localparam logic [11:0] REG_CTRL       = 12'h004;
  localparam logic [11:0] REG_SCRATCH    = 12'h008;
  localparam logic [11:0] REG_CNT_BASE   = 12'h100;
  localparam logic [11:0] REG_CNT_STRIDE = 12'h010;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Counter kind within a port's slot: TX_PKTS, RX_PKTS, RX_ERR_PKTS
  localparam logic [1:0] CNT_TX  = 2'd0;
  localparam logic [1:0] CNT_RX  = 2'd1;
  localparam logic [1:0] CNT_ERR = 2'd2;

  typedef enum logic {WIdle, WResp} w_state_e;
  typedef enum logic {RIdle, RData} r_state_e;

  typedef struct packed {
    logic       hit;
    logic [3:0] port;
    logic [1:0] kind;
  } cnt_dec_t;

  // Port range is checked by the caller, which knows NUM_CMAC_PORT.
  function automatic cnt_dec_t cnt_decode(input logic [11:0] addr);
    cnt_dec_t d;
    logic [11:0] off;
    off    = addr - REG_CNT_BASE;
    d.port = 4'(off / REG_CNT_STRIDE);
    d.kind = addr[3:2];
    d.hit  = (addr[11:8] == REG_CNT_BASE[11:8]) && (addr[3:2] != 2'b11);
    return d;
  endfunction

endpackage

// File: rtl/p2p_sat_counter.sv
// 32-bit event counter; synchronous clear beats increment, saturates at all-ones.
module p2p_sat_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  input  logic        clr,
  output logic [31:0] count
);

  logic [31:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != 32'hFFFF_FFFF)) begin
      count_d = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/p2p_axil_reg.sv
// AXI4-Lite control/status register block: ID, CTRL, SCRATCH and per-port
// saturating packet counters.
module p2p_axil_reg
  import p2p_reg_pkg::*;
#(
  parameter int unsigned NUM_CMAC_PORT = 1,
  parameter logic [31:0] BLOCK_ID      = 32'h5032_5000
) (
  input  logic                     axil_aclk,
  input  logic                     axil_aresetn,
  input  logic                     s_axil_awvalid,
  output logic                     s_axil_awready,
  input  logic [31:0]              s_axil_awaddr,
  input  logic                     s_axil_wvalid,
  output logic                     s_axil_wready,
  input  logic [31:0]              s_axil_wdata,
  output logic                     s_axil_bvalid,
  output logic [1:0]               s_axil_bresp,
  input  logic                     s_axil_bready,
  input  logic                     s_axil_arvalid,
  output logic                     s_axil_arready,
  input  logic [31:0]              s_axil_araddr,
  output logic                     s_axil_rvalid,
  output logic [31:0]              s_axil_rdata,
  output logic [1:0]               s_axil_rresp,
  input  logic                     s_axil_rready,
  input  logic [NUM_CMAC_PORT-1:0] tx_pkt_pulse,
  input  logic [NUM_CMAC_PORT-1:0] rx_pkt_pulse,
  input  logic [NUM_CMAC_PORT-1:0] rx_err_pulse,
  output logic [NUM_CMAC_PORT-1:0] port_en,
  output logic [NUM_CMAC_PORT-1:0] port_loopback
);

  localparam int unsigned NumCnt   = 3 * NUM_CMAC_PORT;
  localparam logic [7:0]  PortMask = 8'((1 << NUM_CMAC_PORT) - 1);
  localparam logic [31:0] CtrlMask = {16'h0, PortMask, PortMask};

  // Goes high on the first edge after reset so the ready outputs stay low in reset.
  logic        live_q;
  w_state_e    w_state_q, w_state_d;
  r_state_e    r_state_q, r_state_d;
  logic        aw_seen_q, aw_seen_d, w_seen_q, w_seen_d;
  logic [11:0] awaddr_q, awaddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        bvalid_q, bvalid_d;
  logic [1:0]  bresp_q, bresp_d;
  logic        rvalid_q, rvalid_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] ctrl_q, ctrl_d, scratch_q, scratch_d;

  logic [31:0]       cnt [NumCnt];
  logic [NumCnt-1:0] cnt_clr;

  logic        aw_hs, w_hs, ar_hs;
  logic [11:0] wr_addr, rd_addr;
  logic [31:0] wr_data;
  cnt_dec_t    wr_dec, rd_dec;
  logic        wr_cnt_ok, rd_cnt_ok;
  int unsigned wr_idx, rd_idx;
  logic [31:0] rd_word;
  logic [1:0]  rd_resp;

  logic unused_addr;
  assign unused_addr = ^{s_axil_awaddr[31:12], s_axil_awaddr[1:0],
                         s_axil_araddr[31:12], s_axil_araddr[1:0]};

  assign s_axil_awready = live_q && (w_state_q == WIdle) && !aw_seen_q;
  assign s_axil_wready  = live_q && (w_state_q == WIdle) && !w_seen_q;
  assign s_axil_arready = live_q && (r_state_q == RIdle);

  assign aw_hs = s_axil_awvalid && s_axil_awready;
  assign w_hs  = s_axil_wvalid && s_axil_wready;
  assign ar_hs = s_axil_arvalid && s_axil_arready;

  assign wr_addr   = aw_hs ? s_axil_awaddr[11:0] : awaddr_q;
  assign wr_data   = w_hs ? s_axil_wdata : wdata_q;
  assign wr_dec    = cnt_decode(wr_addr);
  assign wr_cnt_ok = wr_dec.hit && (32'(wr_dec.port) < NUM_CMAC_PORT);
  assign wr_idx    = 3 * 32'(wr_dec.port) + 32'(wr_dec.kind);

  assign rd_addr   = s_axil_araddr[11:0];
  assign rd_dec    = cnt_decode(rd_addr);
  assign rd_cnt_ok = rd_dec.hit && (32'(rd_dec.port) < NUM_CMAC_PORT);
  assign rd_idx    = 3 * 32'(rd_dec.port) + 32'(rd_dec.kind);

  always_comb begin
    w_state_d = w_state_q;
    aw_seen_d = aw_seen_q;
    w_seen_d  = w_seen_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    ctrl_d    = ctrl_q;
    scratch_d = scratch_q;
    cnt_clr   = '0;
    unique case (w_state_q)
      WIdle: begin
        if (aw_hs) begin
          aw_seen_d = 1'b1;
          awaddr_d  = s_axil_awaddr[11:0];
        end
        if (w_hs) begin
          w_seen_d = 1'b1;
          wdata_d  = s_axil_wdata;
        end
        if ((aw_seen_q || aw_hs) && (w_seen_q || w_hs)) begin
          aw_seen_d = 1'b0;
          w_seen_d  = 1'b0;
          bvalid_d  = 1'b1;
          bresp_d   = RESP_OKAY;
          w_state_d = WResp;
          if ({wr_addr[11:2], 2'b00} == REG_ID) begin
            bresp_d = RESP_OKAY;
          end else if ({wr_addr[11:2], 2'b00} == REG_CTRL) begin
            ctrl_d = wr_data & CtrlMask;
          end else if ({wr_addr[11:2], 2'b00} == REG_SCRATCH) begin
            scratch_d = wr_data;
          end else if (wr_cnt_ok) begin
            for (int unsigned i = 0; i < NumCnt; i++) begin
              if (wr_idx == i) cnt_clr[i] = 1'b1;
            end
          end else begin
            bresp_d = RESP_SLVERR;
          end
        end
      end
      WResp: begin
        if (s_axil_bready) begin
          bvalid_d  = 1'b0;
          w_state_d = WIdle;
        end
      end
      default: w_state_d = WIdle;
    endcase
  end

  always_comb begin
    rd_word = '0;
    rd_resp = RESP_OKAY;
    if ({rd_addr[11:2], 2'b00} == REG_ID) begin
      rd_word = BLOCK_ID;
    end else if ({rd_addr[11:2], 2'b00} == REG_CTRL) begin
      rd_word = ctrl_q;
    end else if ({rd_addr[11:2], 2'b00} == REG_SCRATCH) begin
      rd_word = scratch_q;
    end else if (rd_cnt_ok) begin
      for (int unsigned i = 0; i < NumCnt; i++) begin
        if (rd_idx == i) rd_word = cnt[i];
      end
    end else begin
      rd_resp = RESP_SLVERR;
    end
  end

  always_comb begin
    r_state_d = r_state_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    unique case (r_state_q)
      RIdle: begin
        if (ar_hs) begin
          rvalid_d  = 1'b1;
          rdata_d   = rd_word;
          rresp_d   = rd_resp;
          r_state_d = RData;
        end
      end
      RData: begin
        if (s_axil_rready) begin
          rvalid_d  = 1'b0;
          r_state_d = RIdle;
        end
      end
      default: r_state_d = RIdle;
    endcase
  end

  always_ff @(posedge axil_aclk or negedge axil_aresetn) begin
    if (!axil_aresetn) begin
      live_q    <= 1'b0;
      w_state_q <= WIdle;
      r_state_q <= RIdle;
      aw_seen_q <= 1'b0;
      w_seen_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
      ctrl_q    <= '0;
      scratch_q <= '0;
    end else begin
      live_q    <= 1'b1;
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      aw_seen_q <= aw_seen_d;
      w_seen_q  <= w_seen_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      ctrl_q    <= ctrl_d;
      scratch_q <= scratch_d;
    end
  end

  for (genvar p = 0; p < NUM_CMAC_PORT; p++) begin : g_port
    p2p_sat_counter u_tx (
      .clk   (axil_aclk),
      .rst_n (axil_aresetn),
      .inc   (tx_pkt_pulse[p]),
      .clr   (cnt_clr[3*p + int'(CNT_TX)]),
      .count (cnt[3*p + int'(CNT_TX)])
    );
    p2p_sat_counter u_rx (
      .clk   (axil_aclk),
      .rst_n (axil_aresetn),
      .inc   (rx_pkt_pulse[p]),
      .clr   (cnt_clr[3*p + int'(CNT_RX)]),
      .count (cnt[3*p + int'(CNT_RX)])
    );
    p2p_sat_counter u_err (
      .clk   (axil_aclk),
      .rst_n (axil_aresetn),
      .inc   (rx_err_pulse[p]),
      .clr   (cnt_clr[3*p + int'(CNT_ERR)]),
      .count (cnt[3*p + int'(CNT_ERR)])
    );
  end

  assign s_axil_bvalid = bvalid_q;
  assign s_axil_bresp  = bresp_q;
  assign s_axil_rvalid = rvalid_q;
  assign s_axil_rdata  = rdata_q;
  assign s_axil_rresp  = rresp_q;
  assign port_en       = ctrl_q[NUM_CMAC_PORT-1:0];
  assign port_loopback = ctrl_q[8 +: NUM_CMAC_PORT];

endmodule

// File: tb/tb_p2p_axil_reg.sv
// Directed bench for p2p_axil_reg with two CMAC ports.
module tb_p2p_axil_reg;

  localparam int unsigned NP = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          awvalid = 1'b0, awready;
  logic [31:0]   awaddr = '0;
  logic          wvalid = 1'b0, wready;
  logic [31:0]   wdata = '0;
  logic          bvalid, bready = 1'b0;
  logic [1:0]    bresp;
  logic          arvalid = 1'b0, arready;
  logic [31:0]   araddr = '0;
  logic          rvalid, rready = 1'b0;
  logic [31:0]   rdata;
  logic [1:0]    rresp;
  logic [NP-1:0] tx_pulse = '0, rx_pulse = '0, err_pulse = '0;
  logic [NP-1:0] port_en, port_lb;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  p2p_axil_reg #(
    .NUM_CMAC_PORT (NP),
    .BLOCK_ID      (32'h5032_5000)
  ) dut (
    .axil_aclk      (clk),
    .axil_aresetn   (rst_n),
    .s_axil_awvalid (awvalid),
    .s_axil_awready (awready),
    .s_axil_awaddr  (awaddr),
    .s_axil_wvalid  (wvalid),
    .s_axil_wready  (wready),
    .s_axil_wdata   (wdata),
    .s_axil_bvalid  (bvalid),
    .s_axil_bresp   (bresp),
    .s_axil_bready  (bready),
    .s_axil_arvalid (arvalid),
    .s_axil_arready (arready),
    .s_axil_araddr  (araddr),
    .s_axil_rvalid  (rvalid),
    .s_axil_rdata   (rdata),
    .s_axil_rresp   (rresp),
    .s_axil_rready  (rready),
    .tx_pkt_pulse   (tx_pulse),
    .rx_pkt_pulse   (rx_pulse),
    .rx_err_pulse   (err_pulse),
    .port_en        (port_en),
    .port_loopback  (port_lb)
  );

  logic [NP-1:0] en_at_b, lb_at_b;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input int aw_dly, input int w_dly, input int hold,
                           output logic [1:0] resp, output bit lat_ok, output bit stable);
    bit aw_done = 0, w_done = 0, b_early = 0;
    int c = 0;
    awaddr = addr;
    wdata  = data;
    while (!(aw_done && w_done) && c < 20) begin
      awvalid = !aw_done && (c >= aw_dly);
      wvalid  = !w_done && (c >= w_dly);
      #1;
      b_early = bvalid;
      if (awvalid && awready) aw_done = 1;
      if (wvalid && wready) w_done = 1;
      @(negedge clk);
      c++;
    end
    awvalid = 1'b0;
    wvalid  = 1'b0;
    lat_ok  = aw_done && w_done && !b_early && (bvalid === 1'b1);
    resp    = bresp;
    en_at_b = port_en;
    lb_at_b = port_lb;
    stable  = 1;
    repeat (hold) begin
      @(negedge clk);
      if (bvalid !== 1'b1 || bresp !== resp) stable = 0;
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    if (bvalid !== 1'b0) stable = 0;
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                          output logic [1:0] resp, output bit lat_ok);
    int c = 0;
    araddr  = addr;
    arvalid = 1'b1;
    #1;
    while (!arready && c < 20) begin
      @(negedge clk);
      #1;
      c++;
    end
    @(negedge clk);
    arvalid = 1'b0;
    lat_ok  = (c < 20) && (rvalid === 1'b1);
    data    = rdata;
    resp    = rresp;
    rready  = 1'b1;
    @(negedge clk);
    rready  = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    tests_run++;
    if ({awready, wready, arready, bvalid, rvalid} !== 5'b0 || rdata !== 32'h0
        || bresp !== 2'b00 || rresp !== 2'b00 || port_en !== '0 || port_lb !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got rdy=%b%b%b bv=%b rv=%b rdata=%h en=%b lb=%b, need all 0",
               awready, wready, arready, bvalid, rvalid, rdata, port_en, port_lb);
    end
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({awready, wready, arready} !== 3'b111) begin
      tests_failed++;
      $display("FAIL reset_release_ready: got %b%b%b, need 111", awready, wready, arready);
    end
  endtask

  task automatic test_reset_regs();
    logic [31:0] exp [3];
    logic [31:0] d;
    logic [1:0] r;
    bit ok;
    exp[0] = 32'h5032_5000;
    exp[1] = 32'h0;
    exp[2] = 32'h0;
    for (int i = 0; i < 3; i++) begin
      axi_read(32'(4 * i), d, r, ok);
      tests_run++;
      if (!ok || d !== exp[i] || r !== 2'b00) begin
        tests_failed++;
        $display("FAIL reset_reg_%0d: got ok=%0d data=%h resp=%b, need data=%h resp=00",
                 i, ok, d, r, exp[i]);
      end
    end
  endtask

  task automatic test_ctrl();
    logic [31:0] d;
    logic [1:0] r;
    bit ok, st;
    axi_write(32'h004, 32'hFFFF_FFFF, 0, 0, 0, r, ok, st);
    tests_run++;
    if (!ok || r !== 2'b00 || en_at_b !== 2'b11 || lb_at_b !== 2'b11) begin
      tests_failed++;
      $display("FAIL ctrl_write: got ok=%0d resp=%b en=%b lb=%b, need ok=1 resp=00 en=11 lb=11",
               ok, r, en_at_b, lb_at_b);
    end
    axi_read(32'h004, d, r, ok);
    tests_run++;
    if (!ok || d !== 32'h0000_0303 || r !== 2'b00) begin
      tests_failed++;
      $display("FAIL ctrl_readback: got %h resp=%b, need 00000303 resp=00", d, r);
    end
    axi_write(32'h004, 32'h0000_0102, 0, 0, 0, r, ok, st);
    tests_run++;
    if (!ok || en_at_b !== 2'b10 || lb_at_b !== 2'b01) begin
      tests_failed++;
      $display("FAIL ctrl_pattern: got en=%b lb=%b, need en=10 lb=01", en_at_b, lb_at_b);
    end
  endtask

  task automatic test_write_order();
    logic [31:0] data [3];
    int aw_d [3];
    int w_d [3];
    logic [31:0] d;
    logic [1:0] r;
    bit ok, st;
    data[0] = 32'h1111_2222; aw_d[0] = 1; w_d[0] = 0;
    data[1] = 32'h3333_4444; aw_d[1] = 0; w_d[1] = 1;
    data[2] = 32'hA5A5_5A5A; aw_d[2] = 0; w_d[2] = 0;
    for (int i = 0; i < 3; i++) begin
      axi_write(32'h008, data[i], aw_d[i], w_d[i], (i == 2) ? 5 : 0, r, ok, st);
      tests_run++;
      if (!ok || !st || r !== 2'b00) begin
        tests_failed++;
        $display("FAIL write_order_%0d: got lat_ok=%0d stable=%0d resp=%b, need 1 1 00",
                 i, ok, st, r);
      end
    end
    axi_read(32'h1008, d, r, ok);
    tests_run++;
    if (!ok || d !== 32'hA5A5_5A5A || r !== 2'b00) begin
      tests_failed++;
      $display("FAIL scratch_readback: got %h resp=%b, need a5a55a5a resp=00", d, r);
    end
    axi_write(32'h000, 32'hDEAD_BEEF, 0, 0, 0, r, ok, st);
    axi_read(32'h000, d, r, ok);
    tests_run++;
    if (d !== 32'h5032_5000 || r !== 2'b00) begin
      tests_failed++;
      $display("FAIL id_write_ignored: got %h resp=%b, need 50325000 resp=00", d, r);
    end
  endtask

  task automatic test_counters();
    logic [31:0] d;
    logic [1:0] r;
    bit ok, st;
    repeat (7) begin
      rx_pulse = 2'b10;
      @(negedge clk);
      rx_pulse = 2'b00;
      @(negedge clk);
    end
    axi_read(32'h114, d, r, ok);
    tests_run++;
    if (!ok || d !== 32'd7 || r !== 2'b00) begin
      tests_failed++;
      $display("FAIL rx_cnt_p1: got %0d resp=%b, need 7 resp=00", d, r);
    end
    repeat (2) begin
      err_pulse = 2'b01;
      @(negedge clk);
      err_pulse = 2'b00;
    end
    axi_read(32'h108, d, r, ok);
    tests_run++;
    if (d !== 32'd2) begin
      tests_failed++;
      $display("FAIL err_cnt_p0: got %0d, need 2", d);
    end
    // Clearing write and pulse hit the counter on the same edge.
    awaddr   = 32'h114;
    wdata    = 32'h1234_5678;
    awvalid  = 1'b1;
    wvalid   = 1'b1;
    rx_pulse = 2'b10;
    @(negedge clk);
    awvalid  = 1'b0;
    wvalid   = 1'b0;
    rx_pulse = 2'b00;
    tests_run++;
    if (bvalid !== 1'b1 || bresp !== 2'b00) begin
      tests_failed++;
      $display("FAIL cnt_clear_resp: got bvalid=%b bresp=%b, need 1 00", bvalid, bresp);
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    axi_read(32'h114, d, r, ok);
    tests_run++;
    if (d !== 32'd0) begin
      tests_failed++;
      $display("FAIL clear_beats_pulse: got %0d, need 0", d);
    end
    force dut.g_port[0].u_tx.count_q = 32'hFFFF_FFFE;
    #1;
    release dut.g_port[0].u_tx.count_q;
    @(negedge clk);
    repeat (3) begin
      tx_pulse = 2'b01;
      @(negedge clk);
      tx_pulse = 2'b00;
    end
    axi_read(32'h100, d, r, ok);
    tests_run++;
    if (d !== 32'hFFFF_FFFF) begin
      tests_failed++;
      $display("FAIL tx_saturate: got %h, need ffffffff", d);
    end
  endtask

  task automatic test_errors();
    logic [31:0] addrs [2];
    logic [31:0] d;
    logic [1:0] r;
    bit ok, st;
    addrs[0] = 32'h00C;
    addrs[1] = 32'h120;
    for (int i = 0; i < 2; i++) begin
      axi_read(addrs[i], d, r, ok);
      tests_run++;
      if (!ok || d !== 32'h0 || r !== 2'b10) begin
        tests_failed++;
        $display("FAIL bad_read_%h: got data=%h resp=%b, need 0 resp=10", addrs[i], d, r);
      end
    end
    axi_write(32'h0FC, 32'hFFFF_FFFF, 0, 0, 0, r, ok, st);
    tests_run++;
    if (!ok || r !== 2'b10) begin
      tests_failed++;
      $display("FAIL bad_write_0fc: got ok=%0d resp=%b, need 1 resp=10", ok, r);
    end
  endtask

  task automatic test_reset_mid_read();
    logic [31:0] d;
    logic [1:0] r;
    bit ok;
    araddr  = 32'h008;
    arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (rvalid !== 1'b0 || rdata !== 32'h0 || port_en !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_mid_read: got rvalid=%b rdata=%h en=%b, need 0 0 00",
               rvalid, rdata, port_en);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    axi_read(32'h008, d, r, ok);
    tests_run++;
    if (!ok || d !== 32'h0) begin
      tests_failed++;
      $display("FAIL scratch_after_reset: got %h, need 0", d);
    end
  endtask

  initial begin
    test_reset();
    test_reset_regs();
    test_ctrl();
    test_write_order();
    test_counters();
    test_errors();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete, need completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/p2p_axil_reg.md
# p2p_axil_reg

AXI4-Lite responder that serves the control/status register space of the p2p box on its `s_axil_*` port. It holds per-port control bits (port enable, loopback) and a scratch register. It also keeps 32-bit saturating per-port packet counters fed by single-cycle event pulses from the datapath. The block lives in the `axil_aclk` domain; event pulses arrive already synchronized to that clock.

## Interface
Parameters:
- `NUM_CMAC_PORT`, default 1: number of CMAC ports, legal range 1..4.
- `BLOCK_ID`, default 32'h5032_5000: value returned by the ID register.

Ports:
- `axil_aclk` input 1: the only clock.
- `axil_aresetn` input 1: reset, asynchronous and active-low.
- `s_axil_awvalid`/`s_axil_awready`: input 1 / output 1; `s_axil_awaddr` input 32. Write address channel.
- `s_axil_wvalid`/`s_axil_wready`: input 1 / output 1; `s_axil_wdata` input 32. Write data channel; full-word writes only, no strobes.
- `s_axil_bvalid` output 1, `s_axil_bresp` output 2, `s_axil_bready` input 1: write response channel.
- `s_axil_arvalid`/`s_axil_arready`: input 1 / output 1; `s_axil_araddr` input 32. Read address channel.
- `s_axil_rvalid` output 1, `s_axil_rdata` output 32, `s_axil_rresp` output 2, `s_axil_rready` input 1: read data channel.
- `tx_pkt_pulse` input NUM_CMAC_PORT: one-cycle pulse per transmitted packet (tlast beat), per port.
- `rx_pkt_pulse` input NUM_CMAC_PORT: one-cycle pulse per received packet, per port.
- `rx_err_pulse` input NUM_CMAC_PORT: one-cycle pulse per received packet with tuser_err set, per port.
- `port_en` output NUM_CMAC_PORT: CTRL[NUM_CMAC_PORT-1:0].
- `port_loopback` output NUM_CMAC_PORT: CTRL[8+NUM_CMAC_PORT-1:8].

## Operation
Address decode:
- Decode uses `addr[11:2]`; `addr[31:12]` and `addr[1:0]` are ignored.
- 0x000 ID: read-only, returns `BLOCK_ID`.
- 0x004 CTRL: read/write. Implemented bits are [NUM_CMAC_PORT-1:0] and [8+NUM_CMAC_PORT-1:8]. Unimplemented bits read 0.
- 0x008 SCRATCH: read/write, all 32 bits.
- 0x100+0x10*i, for port i < NUM_CMAC_PORT: TX_PKTS.
- 0x104+0x10*i: RX_PKTS.
- 0x108+0x10*i: RX_ERR_PKTS.

Counter and write behaviour:
- Counters increment by 1 per pulse and saturate at 32'hFFFF_FFFF.
- Any write to a counter clears it to 0, regardless of wdata, with bresp OKAY.
- Clear and pulse in the same cycle: clear wins, counter = 0.
- Write to ID: ignored, bresp OKAY.
- Any other address, including counter slots for i ≥ NUM_CMAC_PORT: write → bresp SLVERR (2'b10); read → rdata 32'h0, rresp SLVERR.

Write FSM, states W_IDLE, W_RESP:
- In W_IDLE, `awready` is high until AW is captured and `wready` is high until W is captured. The two channels are accepted independently, in either order or in the same cycle.
- Once both are captured, the register update and the rise of `bvalid` happen on the same clock edge. The FSM then moves to W_RESP with `awready`=`wready`=0.
- W_RESP holds `bvalid` and `bresp` stable until `bready`; then it returns to W_IDLE.

Read FSM, states R_IDLE, R_DATA:
- `arready` is high in R_IDLE.
- On the AR handshake, the data is registered and `rvalid` rises on the next edge.
- R_DATA holds `rdata` and `rresp` stable until `rready`.

Channel independence:
- The read and write channels operate independently and can be active at the same time.
- A read of a counter in the same cycle as its clearing write returns the pre-clear value.

## Timing
- Reset values: `awready`, `wready`, `arready` = 0 while `axil_aresetn` is low, and 1 from the first edge after release. `bvalid`, `rvalid` = 0; `bresp`, `rresp` = 2'b00; `rdata` = 0.
- Reset values of registers: CTRL = 0 (so `port_en` = `port_loopback` = 0), SCRATCH = 0, all counters = 0.
- Write latency: `bvalid` rises 1 cycle after the later of the AW/W handshakes.
- Read latency: `rvalid` rises 1 cycle after the AR handshake.
- Back-to-back throughput: 1 write per 2 cycles with `bready` held high; 1 read per 2 cycles.
- `port_en` and `port_loopback` change on the same edge `bvalid` rises.
- A pulse on cycle N is visible in a read whose AR handshake is on cycle N+1 or later.
- Reset mid-transaction: both FSMs return to idle immediately and the in-flight response is dropped.

## Structure
- Package `p2p_reg_pkg` holds:
  - register offset constants: `REG_ID`, `REG_CTRL`, `REG_SCRATCH`, `REG_CNT_BASE`, `REG_CNT_STRIDE`;
  - response codes `RESP_OKAY`, `RESP_SLVERR`;
  - FSM state enums for both FSMs.
- Sub-module `p2p_sat_counter`: 32-bit counter with increment, synchronous clear (priority over increment) and saturation. It is instantiated 3×NUM_CMAC_PORT times.

## Test plan
- Reset, then read 0x000, 0x004 and 0x008 → 32'h5032_5000, 0, 0, all rresp OKAY.
- NUM_CMAC_PORT=2: write 0x004 = 32'hFFFF_FFFF, read back → 32'h0000_0303; `port_en`=2'b11 and `port_loopback`=2'b11 on the `bvalid` edge.
- W one cycle before AW, then the opposite order, then both in the same cycle, writing SCRATCH = 32'hA5A5_5A5A → `bvalid` 1 cycle after the later handshake each time. Hold `bready` low 5 cycles → `bvalid`/`bresp` stable. Readback = 32'hA5A5_5A5A.
- 7 `rx_pkt_pulse[1]` → read 0x114 = 7. Write 0x114 in the same cycle as a pulse → subsequent read = 0.
- Force TX_PKTS[0] to 32'hFFFF_FFFE, send 3 pulses → read 0x100 = 32'hFFFF_FFFF.
- Read 0x00C and 0x120 (NUM_CMAC_PORT=2), write 0x0FC → rresp/bresp 2'b10, rdata 0. Assert reset while `rvalid` is pending → `rvalid`=0 immediately.
